hazard_ctrl_unit: RTL

- Central hazard/stall sequencer for the 5-stage RV32IM pipeline.
- Drives hold and flush controls for the PC, IF/ID and ID/EX registers.
- Handles three hazards: load-use stalls, taken branch/jump flushes, and multi-cycle MUL/DIV stalls.
- Tracks branches that resolve during an instruction-memory miss, so the late wrong-path fetch is discarded.

---
 rtl/hazard_ctrl_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall sequencer for the 5-stage RV32IM pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle MUL/DIV stalls and flushes across an I-miss.
module hazard_ctrl_unit #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] RS1_ID,
  input  logic [4:0] RS2_ID,
  input  logic       RS1_USE_ID,
  input  logic       RS2_USE_ID,
  input  logic [4:0] RD_IDEX,
  input  logic       MEM_READ_IDEX,
  input  logic       BRANCH_TAKEN_EX,
  input  logic       MULDIV_START_EX,
  input  logic       DIV_OP_EX,
  input  logic       MEM_BUSYWAIT,
  input  logic       IMEM_BUSYWAIT,
  output logic       HOLD_PC,
  output logic       HOLD_IFID,
  output logic       HOLD_IDEX,
  output logic       HAZARD_RESET_IFID,
  output logic       HAZARD_RESET_IDEX,
  output logic       MULDIV_BUSY,
  output logic [1:0] DEBUG_STATE
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MD_WAIT     = 2'd1,
    IMISS_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_LATENCY);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] lat;
  logic             lu;

  assign lu = MEM_READ_IDEX && (RD_IDEX != 5'd0) &&
              ((RS1_USE_ID && (RS1_ID == RD_IDEX)) ||
               (RS2_USE_ID && (RS2_ID == RD_IDEX)));
  assign lat = DIV_OP_EX ? DIV_LAT : MUL_LAT;
  assign DEBUG_STATE = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    HOLD_PC           = 1'b0;
    HOLD_IFID         = 1'b0;
    HOLD_IDEX         = 1'b0;
    HAZARD_RESET_IFID = 1'b0;
    HAZARD_RESET_IDEX = 1'b0;
    MULDIV_BUSY       = 1'b0;
    case (state)
      IDLE: begin
        if (!MEM_BUSYWAIT) begin
          if (BRANCH_TAKEN_EX) begin
            HAZARD_RESET_IFID = 1'b1;
            HAZARD_RESET_IDEX = 1'b1;
            if (IMEM_BUSYWAIT) state_next = IMISS_FLUSH;
          end else if (MULDIV_START_EX) begin
            HOLD_PC   = 1'b1;
            HOLD_IFID = 1'b1;
            HOLD_IDEX = 1'b1;
            // This cycle is the first of LAT stall cycles.
            if (lat > CNT_W'(1)) begin
              state_next = MD_WAIT;
              cnt_next   = lat - CNT_W'(2);
            end
          end else if (lu) begin
            HOLD_PC           = 1'b1;
            HOLD_IFID         = 1'b1;
            HAZARD_RESET_IDEX = 1'b1;
          end
        end
      end
      MD_WAIT: begin
        MULDIV_BUSY = 1'b1;
        HOLD_PC     = !MEM_BUSYWAIT;
        HOLD_IFID   = !MEM_BUSYWAIT;
        HOLD_IDEX   = !MEM_BUSYWAIT;
        // The M unit keeps counting even while data memory freezes the pipe.
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      IMISS_FLUSH: begin
        if (!MEM_BUSYWAIT) begin
          HAZARD_RESET_IFID = 1'b1;
          HAZARD_RESET_IDEX = BRANCH_TAKEN_EX;
          if (!IMEM_BUSYWAIT) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (RESET) begin
      HOLD_PC           = 1'b0;
      HOLD_IFID         = 1'b0;
      HOLD_IDEX         = 1'b0;
      HAZARD_RESET_IFID = 1'b0;
      HAZARD_RESET_IDEX = 1'b0;
      MULDIV_BUSY       = 1'b0;
    end
  end

endmodule
